// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: initialises registers 1..31, then round-robins
// the ALU and MEM writeback channels onto a single register-file write port.
module rf_wb_arbiter #(
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        rf_we,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        init_done,
  output logic [15:0] wr_count
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   init_cnt;
  logic                rr_ptr;
  logic                grant0, grant1, xfer;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [DATA_W-1:0]   xfer_data;

  logic                vld_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic                init_done_p1;
  logic [CNT_W-1:0]    cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage 0: combinational grant; rr_ptr=0 favours req0, 1 favours req1
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    case (state)
      ST_INIT: begin
        if (init_cnt == 5'd31) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (rst) begin
          if (req0_valid && (!req1_valid || !rr_ptr)) grant0 = 1'b1;
          else if (req1_valid)                        grant1 = 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign xfer      = grant0 | grant1;
  assign xfer_addr = grant0 ? req0_addr : req1_addr;
  assign xfer_data = grant0 ? req0_data : req1_data;

  // Stage 1: registered register-file write port and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_INIT;
      init_cnt     <= 5'd1;
      rr_ptr       <= 1'b0;
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
      init_done_p1 <= 1'b0;
      cnt_p1       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_INIT: begin
          vld_p1   <= 1'b1;
          addr_p1  <= init_cnt;
          data_p1  <= INIT_VALUE;
          init_cnt <= init_cnt + 5'd1;
        end
        default: begin
          init_done_p1 <= 1'b1;
          vld_p1       <= xfer && (xfer_addr != '0);
          if (xfer) rr_ptr <= grant0;
          // Address-0 transfers are acknowledged but never reach the file
          if (xfer && (xfer_addr != '0)) begin
            addr_p1 <= xfer_addr;
            data_p1 <= xfer_data;
            cnt_p1  <= sat_inc(cnt_p1);
          end
        end
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rf_we      = vld_p1;
  assign rf_wr_addr = addr_p1;
  assign rf_wr_data = data_p1;
  assign init_done  = init_done_p1;
  assign wr_count   = cnt_p1;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: init sequence, arbitration table,
// reset restarts and write-counter saturation.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        init_done;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        exp_r0;
    logic        exp_r1;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];

  rf_wb_arbiter #(.INIT_VALUE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .init_done(init_done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // One RUN cycle: drive, check grants, queue the expected write, check it after the edge
  task automatic step(input vec_t v, input string tag);
    exp_t e, got;
    set_req(v.v0, v.a0, v.d0, v.v1, v.a1, v.d1);
    #1;
    chk({tag, " req0_ready"}, 32'(req0_ready), 32'(v.exp_r0));
    chk({tag, " req1_ready"}, 32'(req1_ready), 32'(v.exp_r1));
    e.we = v.exp_we; e.addr = v.exp_addr; e.data = v.exp_data; e.cnt = v.exp_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty queue, required one entry", tag);
    end else begin
      got = sb.pop_front();
      chk({tag, " rf_we"},      32'(rf_we),      32'(got.we));
      chk({tag, " rf_wr_addr"}, 32'(rf_wr_addr), 32'(got.addr));
      chk({tag, " rf_wr_data"}, rf_wr_data,      got.data);
      chk({tag, " wr_count"},   32'(wr_count),   32'(got.cnt));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rf_we"},      32'(rf_we),      32'd0);
    chk({tag, " rf_wr_addr"}, 32'(rf_wr_addr), 32'd0);
    chk({tag, " rf_wr_data"}, rf_wr_data,      32'd0);
    chk({tag, " init_done"},  32'(init_done),  32'd0);
    chk({tag, " wr_count"},   32'(wr_count),   32'd0);
    chk({tag, " req0_ready"}, 32'(req0_ready), 32'd0);
    chk({tag, " req1_ready"}, 32'(req1_ready), 32'd0);
  endtask

  // Releases reset (called at posedge+1 with rst low) and checks writes 1..last
  task automatic init_writes(input int last, input bit drive_valid);
    rst = 1'b1;
    for (int i = 1; i <= last; i++) begin
      if (drive_valid && i < 31) set_req(1'b1, 5'd3, 32'h1111_0003, 1'b1, 5'd4, 32'h2222_0004);
      else                       set_req(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("init%0d rf_we", i),      32'(rf_we),      32'd1);
      chk($sformatf("init%0d rf_wr_addr", i), 32'(rf_wr_addr), 32'(i));
      chk($sformatf("init%0d rf_wr_data", i), rf_wr_data,      32'h0);
      chk($sformatf("init%0d init_done", i),  32'(init_done),  32'd0);
      chk($sformatf("init%0d req0_ready", i), 32'(req0_ready), 32'd0);
      chk($sformatf("init%0d req1_ready", i), 32'(req1_ready), 32'd0);
    end
  endtask

  task automatic full_init(input bit drive_valid);
    init_writes(31, drive_valid);
    @(posedge clk); #1;
    chk("post_init init_done", 32'(init_done), 32'd1);
    chk("post_init rf_we",     32'(rf_we),     32'd0);
    chk("post_init wr_count",  32'(wr_count),  32'd0);
  endtask

  initial begin
    vec_t v;
    //            v0  a0     d0            v1  a1     d1            r0 r1 we addr   data          cnt
    tbl[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,        1, 0, 1, 5'd5, 32'hDEAD_BEEF, 16'd1};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,        0, 0, 0, 5'd5, 32'hDEAD_BEEF, 16'd1};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'h0000_1234, 0, 1, 0, 5'd5, 32'hDEAD_BEEF, 16'd1};
    tbl[3]  = '{1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1, 0, 1, 5'd3, 32'hA0A0_0003, 16'd2};
    tbl[4]  = '{1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 0, 1, 1, 5'd7, 32'hB1B1_0007, 16'd3};
    tbl[5]  = '{1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 1, 0, 1, 5'd3, 32'hA0A0_0003, 16'd4};
    tbl[6]  = '{1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd7, 32'hB1B1_0007, 0, 1, 1, 5'd7, 32'hB1B1_0007, 16'd5};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 32'h9999_0009, 0, 1, 1, 5'd9, 32'h9999_0009, 16'd6};
    tbl[8]  = '{1'b1, 5'd2, 32'h2222_0002, 1'b1, 5'd4, 32'h4444_0004, 1, 0, 1, 5'd2, 32'h2222_0002, 16'd7};
    tbl[9]  = '{1'b1, 5'd2, 32'h2222_0002, 1'b1, 5'd4, 32'h4444_0004, 0, 1, 1, 5'd4, 32'h4444_0004, 16'd8};
    tbl[10] = '{1'b1, 5'd0, 32'h5555_5555, 1'b0, 5'd0, 32'h0,        1, 0, 0, 5'd4, 32'h4444_0004, 16'd8};
    tbl[11] = '{1'b1, 5'd6, 32'h6666_0006, 1'b1, 5'd8, 32'h8888_0008, 0, 1, 1, 5'd8, 32'h8888_0008, 16'd9};
    tbl[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,        0, 0, 0, 5'd8, 32'h8888_0008, 16'd9};

    rst = 1'b0;
    set_req(1'b1, 5'd3, 32'h1111_0003, 1'b1, 5'd4, 32'h2222_0004);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");

    full_init(1'b1);

    for (int i = 0; i < 13; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Reset in RUN with a pending request: no grant, state cleared
    set_req(1'b1, 5'd5, 32'h0BAD_0005, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_run req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    chk_reset_state("rst_run");

    // Reset while initialising address 10, then a complete restart
    init_writes(10, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("rst_init");
    full_init(1'b0);

    // Saturation: both requesters streaming, pointer returns to req0 after an even count
    set_req(1'b1, 5'd1, 32'hC0DE_0001, 1'b1, 5'd2, 32'hC0DE_0002);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat pre wr_count", 32'(wr_count), 32'h0000_FFFE);
    v = '{1'b1, 5'd1, 32'hC0DE_0001, 1'b1, 5'd2, 32'hC0DE_0002, 1, 0, 1, 5'd1, 32'hC0DE_0001, 16'hFFFF};
    step(v, "sat1");
    v = '{1'b1, 5'd1, 32'hC0DE_0001, 1'b1, 5'd2, 32'hC0DE_0002, 0, 1, 1, 5'd2, 32'hC0DE_0002, 16'hFFFF};
    step(v, "sat2");
    v = '{1'b1, 5'd1, 32'hC0DE_0001, 1'b1, 5'd2, 32'hC0DE_0002, 1, 0, 1, 5'd1, 32'hC0DE_0001, 16'hFFFF};
    step(v, "sat3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
